inst_rom_loader: RTL

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader.sv | 74 +++++++
 1 files changed

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction ROM that is loaded byte-serially (MSB first) while it holds the core in reset.
module inst_rom_loader #(
   parameter int DEPTH = 1024,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic [31:0]   addr,
   output logic [31:0]   inst,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [7:0]    ld_byte,
   input  logic          ld_end,
   output logic          ld_ready,
   output logic          ld_done,
   output logic          cpu_hold,
   output logic          ld_overflow,
   output logic [AW:0]   word_count
);
   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;
   state_t state, state_nxt;
   logic [31:0] mem [DEPTH];
   logic [31:0] asm_word, wdata;
   logic [1:0] bcnt;
   logic full, we, unused_addr;
   // word_count doubles as the write pointer; it saturates at DEPTH instead of wrapping
   assign full = word_count == (AW + 1)'(DEPTH);
   assign we = !rst && !ld_start && (state == LOAD ? ld_valid && !full && bcnt == 2'd3 :
                                     state == COMMIT && bcnt != 2'd0 && !full);
   assign wdata = state == COMMIT ? asm_word : {asm_word[31:8], ld_byte};
   assign inst = ce && !cpu_hold ? mem[addr[AW+1:2]] : '0;
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = ld_start ? LOAD :
                  state == LOAD ? (ld_end ? COMMIT : LOAD) :
                  state == COMMIT ? DONE : IDLE;
   end
   always_comb begin
      ld_ready = state == LOAD;
      ld_done = state == DONE;
      cpu_hold = state != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst || ld_start) begin
         word_count <= '0;
         bcnt <= '0;
         asm_word <= '0;
         ld_overflow <= 1'b0;
      end else if (state == LOAD && ld_valid) begin
         if (full) ld_overflow <= 1'b1;
         else if (bcnt == 2'd3) begin
            word_count <= word_count + 1'b1;
            bcnt <= '0;
            asm_word <= '0;
         end else begin
            asm_word <= asm_word | ({24'd0, ld_byte} << {~bcnt, 3'd0});
            bcnt <= bcnt + 1'b1;
         end
      end else if (we) begin
         word_count <= word_count + 1'b1;
         bcnt <= '0;
         asm_word <= '0;
      end
   end
   // memory has no reset so programs survive rst and restarts
   always_ff @(posedge clk) begin
      if (we) mem[word_count[AW-1:0]] <= wdata;
   end
endmodule
